// File: rtl/float_add_arbiter.sv
// float_add_arbiter: shares one registered float_24_8 adder among NREQ requesters.
// Requesters are granted one per cycle (round-robin by default), ids ride an
// ADD_LAT-deep shift register next to the adder, and sums land in a result FIFO
// in issue order. Issue is credit-gated so the FIFO can never overflow.
//
// Build option: define FLOAT_ADD_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins); otherwise round-robin starting after the most recent grant.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high.
// A source holds valid and data stable until accepted and never derives valid
// from ready; ready may depend combinationally on valid (req_ready does).
// Operands are packed {sgn, exp[7:0], man[22:0]}, 32 bits per lane.
module float_add_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADD_LAT    = 1,
  parameter int FIFO_DEPTH = 4   // must be >= ADD_LAT+1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  input  logic [31:0]             add_sum,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [31:0]             res_data
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + ADD_LAT + 2);

  // In-flight tracking alongside the adder pipeline
  logic [ADD_LAT-1:0] sr_v;
  logic [IDW-1:0]     sr_id [ADD_LAT];

  // Result FIFO
  logic [IDW-1:0]     mem_id   [FIFO_DEPTH];
  logic [31:0]        mem_data [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      occ;

  logic [CW-1:0]      infl;
  logic               push;
  logic               pop;
  logic               permit;
  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic               issue;

`ifndef FLOAT_ADD_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]     last_q;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push      = sr_v[ADD_LAT-1];
  assign res_valid = (occ != '0);
  assign pop       = res_valid & res_ready;
  assign res_id    = res_valid ? mem_id[rd_ptr]   : '0;
  assign res_data  = res_valid ? mem_data[rd_ptr] : '0;

  // Count operations still inside the adder pipeline
  always_comb begin
    infl = '0;
    for (int s = 0; s < ADD_LAT; s++) begin
      infl = infl + CW'(sr_v[s]);
    end
  end

  // Credit: every in-flight op plus every stored result needs a FIFO slot;
  // a pop this cycle frees one. Written without subtraction to avoid wrap.
  assign permit = (infl + occ) < (CW'(FIFO_DEPTH) + CW'(pop));

  // Pick the winning requester among those presenting valid
  always_comb begin
    logic [IDW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
`ifdef FLOAT_ADD_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'(i);
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
`endif
  end

  // Grant, issue and adder operand drive; everything quiet while in reset
  always_comb begin
    req_ready = '0;
    issue     = 1'b0;
    add_a     = '0;
    add_b     = '0;
    if (!reset && win_found && permit) begin
      req_ready[win_idx] = 1'b1;
      issue              = 1'b1;
      add_a              = req_a[win_idx*32 +: 32];
      add_b              = req_b[win_idx*32 +: 32];
    end
  end

`ifndef FLOAT_ADD_ARB_FIXED_PRIO_EN
  // Remember the most recent grant for the round-robin search
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= IDW'(NREQ - 1);
    end else if (issue) begin
      last_q <= win_idx;
    end
  end
`endif

  // Shift the requester id along with the adder latency
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_v <= '0;
      for (int s = 0; s < ADD_LAT; s++) begin
        sr_id[s] <= '0;
      end
    end else begin
      for (int s = ADD_LAT - 1; s > 0; s--) begin
        sr_v[s]  <= sr_v[s-1];
        sr_id[s] <= sr_id[s-1];
      end
      sr_v[0]  <= issue;
      sr_id[0] <= win_idx;
    end
  end

  // Result FIFO: capture the sum when its id leaves the pipeline, pop on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem_id[wr_ptr]   <= sr_id[ADD_LAT-1];
        mem_data[wr_ptr] <= add_sum;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  // The credit rule must make a push into a full FIFO impossible
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && occ == CW'(FIFO_DEPTH)))
        else $error("result fifo overflow");
    end
  end
`endif

endmodule

// File: tb/tb_float_add_arbiter.sv
// tb_float_add_arbiter: drives float_add_arbiter with a behavioural adder stub
// and checks it against a queue-based reference model every cycle.
module tb_float_add_arbiter;

  localparam int NREQ       = 4;
  localparam int ADD_LAT    = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = $clog2(NREQ);
  localparam int W          = IDW + 32;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_a;
  logic [NREQ*32-1:0]   req_b;
  logic [31:0]          add_a;
  logic [31:0]          add_b;
  logic [31:0]          add_sum;
  logic                 res_valid;
  logic                 res_ready;
  logic [IDW-1:0]       res_id;
  logic [31:0]          res_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: issued results in order, with the cycle each becomes visible
  logic [W-1:0] exp_q[$];
  int           rdy_q[$];
  int           last_m;

  // Values observed at the most recent sample point
  logic [NREQ-1:0] obs_ready;
  logic            obs_res_valid;
  logic [IDW-1:0]  obs_res_id;
  logic [31:0]     obs_res_data;
  logic [NREQ-1:0] last_acc;

  float_add_arbiter #(
    .NREQ(NREQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // float_24_8 <-> real helpers (normal numbers and zero)
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    if (f[31]) r = -r;
    return r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    return {1'b0, 8'($urandom_range(100, 150)), 23'($urandom())};
  endfunction

  // Adder stub with ADD_LAT = 1 register stage
  always @(posedge clk) add_sum <= fadd(add_a, add_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, compare with the model, advance model
  task automatic step();
    logic [NREQ-1:0] e_ready;
    logic            e_valid;
    logic            e_pop;
    logic            found;
    logic [31:0]     ea;
    logic [31:0]     eb;
    int              win;
    int              idx;
    @(negedge clk);
    obs_ready     = req_ready;
    obs_res_valid = res_valid;
    obs_res_id    = res_id;
    obs_res_data  = res_data;

    e_valid = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
    chk("res_valid", 32'(res_valid), 32'(e_valid));
    if (e_valid) begin
      chk("res_id", 32'(res_id), 32'(exp_q[0][W-1:32]));
      chk("res_data", res_data, exp_q[0][31:0]);
    end
    e_pop = e_valid & res_ready;

    found = 1'b0;
    win   = 0;
`ifdef FLOAT_ADD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin found = 1'b1; win = i; end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last_m + k) % NREQ;
      if (!found && req_valid[idx]) begin found = 1'b1; win = idx; end
    end
`endif
    e_ready = '0;
    if (!reset && found && (exp_q.size() - int'(e_pop) < FIFO_DEPTH)) e_ready[win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    ea = (e_ready != '0) ? req_a[win*32 +: 32] : 32'd0;
    eb = (e_ready != '0) ? req_b[win*32 +: 32] : 32'd0;
    chk("add_a", add_a, ea);
    chk("add_b", add_b, eb);

    last_acc = e_ready & req_valid;
    if (reset) begin
      exp_q.delete();
      rdy_q.delete();
      last_m = NREQ - 1;
    end else begin
      if (e_pop) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (e_ready != '0) begin
        exp_q.push_back({IDW'(win), fadd(ea, eb)});
        rdy_q.push_back(cyc + ADD_LAT + 1);
        last_m = win;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Requesters: keep unaccepted operands stable, replace accepted/idle lanes
  task automatic refresh(input int pct);
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i] || last_acc[i]) begin
        req_valid[i]       = ($urandom_range(0, 99) < pct);
        req_a[i*32 +: 32]  = rnd_f();
        req_b[i*32 +: 32]  = rnd_f();
      end
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = v;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  // Reset with requesters asserting valid to confirm nothing is granted
  task automatic do_reset();
    reset     = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, rnd_f(), rnd_f());
    step();
    step();
    chk("rst_ready", 32'(obs_ready), 32'd0);
    chk("rst_res_valid", 32'(obs_res_valid), 32'd0);
    chk("rst_res_id", 32'(obs_res_id), 32'd0);
    chk("rst_res_data", obs_res_data, 32'd0);
    reset     = 1'b0;
    req_valid = '0;
    last_acc  = '0;
  endtask

  initial begin
    int acc;
    int pops;
    logic [NREQ-1:0] exp_g;

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    last_m    = NREQ - 1;
    last_acc  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    do_reset();

    // Single issue: 1.0 + 2.0 returns 3.0 two cycles later with id 0
    set_lane(0, 1'b1, 32'h3F800000, 32'h40000000);
    step();
    chk("single_ready", 32'(obs_ready), 32'd1);
    req_valid = '0;
    step();
    step();
    chk("single_valid", 32'(obs_res_valid), 32'd1);
    chk("single_id", 32'(obs_res_id), 32'd0);
    chk("single_data", obs_res_data, 32'h40400000);
    repeat (2) step();

    // Rotation: all requesters valid, no backpressure
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, rnd_f(), rnd_f());
    for (int k = 0; k < 12; k++) begin
      step();
`ifdef FLOAT_ADD_ARB_FIXED_PRIO_EN
      exp_g = NREQ'(1);
`else
      exp_g = NREQ'(1) << (k % NREQ);
`endif
      chk("rot_grant", 32'(obs_ready), 32'(exp_g));
      refresh(100);
    end
    req_valid = '0;
    repeat (4) step();

    // Backpressure: exactly FIFO_DEPTH accepts, then one per freed slot
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, rnd_f(), rnd_f());
    acc  = 0;
    pops = 0;
    for (int k = 0; k < 7; k++) begin
      step();
      if ((obs_ready & req_valid) != '0) acc++;
      refresh(100);
    end
    chk("bp_accepts", 32'(acc), 32'(FIFO_DEPTH));
    chk("bp_stalled", 32'(obs_ready), 32'd0);
    acc       = 0;
    res_ready = 1'b1;
    step();
    if ((obs_ready & req_valid) != '0) acc++;
    if (obs_res_valid) pops++;
    refresh(100);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if ((obs_ready & req_valid) != '0) acc++;
      refresh(100);
    end
    chk("bp_one_more", 32'(acc), 32'd1);
    req_valid = '0;
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (obs_res_valid) pops++;
    end
    chk("bp_results", 32'(pops), 32'(FIFO_DEPTH + 1));

    // Sparse: req 2 alone, then req 1 alone (search wraps past 3 and 0)
    do_reset();
    repeat (2) step();
    set_lane(2, 1'b1, rnd_f(), rnd_f());
    step();
    chk("sparse_r2", 32'(obs_ready), 32'd4);
    set_lane(2, 1'b0, 32'd0, 32'd0);
    set_lane(1, 1'b1, rnd_f(), rnd_f());
    step();
    chk("sparse_r1", 32'(obs_ready), 32'd2);
    req_valid = '0;
    repeat (4) step();

    // Reset mid-flight: reset lands on the cycle the first sum is captured
    do_reset();
    set_lane(0, 1'b1, rnd_f(), rnd_f());
    set_lane(1, 1'b1, rnd_f(), rnd_f());
    step();
    chk("mid_first", 32'(obs_ready), 32'd1);
    set_lane(0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = '0;
    step();
    chk("mid_after_rst", 32'(obs_res_valid), 32'd0);
    repeat (4) step();
    set_lane(0, 1'b1, rnd_f(), rnd_f());
    set_lane(3, 1'b1, rnd_f(), rnd_f());
    step();
    chk("mid_first_grant", 32'(obs_ready), 32'd1);

    // Requesters 0 and 3 held valid, then 0 drops
    for (int k = 1; k < 6; k++) begin
      refresh(100);
      req_valid[1] = 1'b0;
      req_valid[2] = 1'b0;
      step();
`ifdef FLOAT_ADD_ARB_FIXED_PRIO_EN
      exp_g = NREQ'(1);
`else
      exp_g = (k % 2 == 1) ? NREQ'(8) : NREQ'(1);
`endif
      chk("pair_grant", 32'(obs_ready), 32'(exp_g));
    end
    refresh(100);
    req_valid = '0;
    set_lane(3, 1'b1, rnd_f(), rnd_f());
    step();
    chk("pair_drop0", 32'(obs_ready), 32'd8);
    req_valid = '0;
    repeat (4) step();

    // Random traffic with random backpressure
    do_reset();
    for (int k = 0; k < 600; k++) begin
      res_ready = ($urandom_range(0, 99) < 70);
      refresh(60);
      step();
    end
    req_valid = '0;
    res_ready = 1'b1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
